dds_tune_ctrl: RTL and testbench
================================

// Module: dds_tune_ctrl
// PURPOSE
//  Sequences frequency and waveform updates into the DDS phase accumulator.
//  Consumes the committed count (Address/FreqChng) from the rotary front end and the
//  front-panel Mode, and converts the count to a 32-bit tuning word.
//  Applies word and waveform together on a phase-wrap boundary for glitch-free retune.
//  Sits between the rotary interface and the phase accumulator/waveform ROM.
// PARAMETERS
//  ADDR_W      11         width of Address (count range 0..1800)
//  TW_W        32         tuning-word width
//  K_STEP      32'd179    tuning word per count (~1 Hz/count at 24 MHz, 2^32/24e6)
//  WRAP_TMO    2400000    max cycles to wait for PhaseWrap (100 ms @ 24 MHz)
// PORTS
//  Fg_CLK     in   1       system clock
//  RESET      in   1       asynchronous, active-high reset
//  Address    in   ADDR_W  committed frequency count
//  FreqChng   in   1       1-cycle pulse: Address holds a new value
//  Mode       in   3       waveform select from panel
//  PhaseWrap  in   1       1-cycle pulse when accumulator MSB wraps 1->0
//  LoadAck    in   1       accumulator has latched TuneWord/WaveSel
//  TuneWord   out  TW_W    tuning word, stable while TuneLoad=1
//  WaveSel    out  3       waveform select, updated with TuneWord
//  TuneLoad   out  1       load request, held until LoadAck
//  Busy       out  1       1 in any state other than IDLE
//  WrapTmo    out  1       sticky: last load was forced by timeout; cleared on next wrap-aligned load
// BEHAVIOUR
//  Reset (async, immediate): TuneWord=0, WaveSel=0, TuneLoad=0, Busy=0, WrapTmo=0,
//   applied-word register=0, pending=0, state=IDLE. Reset mid-operation abandons the request.
//  Request: FreqChng=1, or Mode != registered Mode_q (Mode_q updated when the request is taken).
//  FSM: IDLE -> CALC -> WAIT_WRAP -> LOAD -> IDLE.
//   IDLE: on request (or pending=1), latch Address into addr_q and Mode into mode_q, clear
//    pending, go to CALC next cycle.
//   CALC: shift-add multiply addr_q*K_STEP, one bit per cycle, exactly ADDR_W cycles.
//    Product truncated to TW_W bits (max 2047*179 fits). Then WAIT_WRAP.
//   WAIT_WRAP: go to LOAD on PhaseWrap. Skip directly to LOAD if applied word == 0
//    (accumulator frozen, no wrap).
//    Timeout counter reaching WRAP_TMO -> LOAD with WrapTmo=1.
//   LOAD: TuneWord=product, WaveSel=mode_q, TuneLoad=1. Hold until LoadAck is sampled 1.
//    Then TuneLoad=0, applied word=product, and IDLE the same edge.
//    LoadAck already high on LOAD entry -> single-cycle TuneLoad.
//  Requests while Busy set pending=1. Address/Mode are re-sampled in IDLE, so the
//   latest value wins and intermediate values are dropped.
//  Pending serviced on the IDLE cycle after LOAD; no extra idle cycle.
//  Latency FreqChng -> TuneLoad: 1 + ADDR_W + wait + 1 cycles.
//   Wrap already pending or word 0: 13 cycles min.
//  PhaseWrap outside WAIT_WRAP is ignored. FreqChng coincident with LoadAck sets pending.
//  Address=0 gives TuneWord=0 (output DC); next request skips the wrap wait.
// STRUCTURE
//  dds_pkg: state enum (IDLE/CALC/WAIT_WRAP/LOAD), ADDR_W, TW_W, K_STEP default, mode codes.
//  Sub-module dds_shift_add_mul (start/done, ADDR_W x TW_W -> TW_W sequential multiplier).
//  Top holds FSM, pending logic, timeout counter, output registers.
// TESTING
//  1 Address=1000, FreqChng pulse, PhaseWrap 5 cyc after CALC ends, LoadAck same cycle as TuneLoad
//    -> TuneWord=32'h0002_BB38, TuneLoad 1 cycle, Busy low after.
//  2 Applied word 0, Address=1 -> TuneLoad at cycle 13 after FreqChng, TuneWord=179, no wrap needed.
//  3 Address=500 then 700 while in WAIT_WRAP -> first load 89500, then second load 125300, no 500-era repeat.
//  4 No PhaseWrap for WRAP_TMO cycles -> TuneLoad issued at timeout, WrapTmo=1;
//    next wrap-aligned load clears it.
//  5 Mode 0->3 with no FreqChng -> WaveSel=3 loaded at wrap, TuneWord unchanged.
//  6 RESET asserted while TuneLoad=1, LoadAck low -> all outputs 0 immediately, IDLE, pending=0.

Source files
------------

// File: rtl/dds_pkg.sv
// dds_pkg: shared state encoding, widths and waveform codes for the DDS tuning controller
package dds_pkg;
  localparam int ADDR_W = 11;
  localparam int TW_W = 32;
  localparam logic [31:0] K_STEP = 32'd179;
  localparam logic [2:0] MODE_SINE = 3'd0;
  localparam logic [2:0] MODE_TRI = 3'd1;
  localparam logic [2:0] MODE_SAW = 3'd2;
  localparam logic [2:0] MODE_SQR = 3'd3;
  typedef enum logic [1:0] {IDLE, CALC, WAIT_WRAP, LOAD} state_t;
endpackage

// File: rtl/dds_shift_add_mul.sv
// dds_shift_add_mul: sequential shift-add multiplier, one multiplier bit per cycle, AW cycles per product
module dds_shift_add_mul #(
  parameter int AW = dds_pkg::ADDR_W,
  parameter int BW = dds_pkg::TW_W
) (
  input  logic          Fg_CLK,
  input  logic          RESET,
  input  logic          start,
  input  logic [AW-1:0] a,
  input  logic [BW-1:0] b,
  output logic          done,
  output logic [BW-1:0] p
);
  localparam int CW = $clog2(AW + 1);
  logic [AW-1:0] a_r;
  logic [BW-1:0] b_r;
  logic [CW-1:0] cnt;
  always_ff @(posedge Fg_CLK or posedge RESET)
    if (RESET) begin
      a_r <= '0;
      b_r <= '0;
      p <= '0;
      cnt <= '0;
    end else if (start) begin
      a_r <= a;
      b_r <= b;
      p <= '0;
      cnt <= CW'(AW);
    end else if (cnt != '0) begin
      p <= a_r[0] ? p + b_r : p;
      a_r <= a_r >> 1;
      b_r <= b_r << 1;
      cnt <= cnt - 1'b1;
    end
  // high during the cycle whose edge performs the final accumulate
  assign done = cnt == CW'(1);
endmodule

// File: rtl/dds_tune_ctrl.sv
// dds_tune_ctrl: converts committed count and mode into a tuning word, applied on a phase-wrap boundary
module dds_tune_ctrl #(
  parameter int          ADDR_W   = dds_pkg::ADDR_W,
  parameter int          TW_W     = dds_pkg::TW_W,
  parameter logic [31:0] K_STEP   = dds_pkg::K_STEP,
  parameter int          WRAP_TMO = 2400000
) (
  input  logic              Fg_CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] Address,
  input  logic              FreqChng,
  input  logic [2:0]        Mode,
  input  logic              PhaseWrap,
  input  logic              LoadAck,
  output logic [TW_W-1:0]   TuneWord,
  output logic [2:0]        WaveSel,
  output logic              TuneLoad,
  output logic              Busy,
  output logic              WrapTmo
);
  import dds_pkg::*;
  localparam int TMO_W = $clog2(WRAP_TMO + 1);
  state_t state, state_nx;
  logic [2:0] mode_q;
  logic pending, req, take, wrap_ok, tmo_hit, mul_done;
  logic [TW_W-1:0] product, applied;
  logic [TMO_W-1:0] tmo_cnt;
  assign req = FreqChng || Mode != mode_q;
  assign take = state == IDLE && (req || pending);
  // a zero word freezes the accumulator, so no wrap will ever arrive
  assign wrap_ok = PhaseWrap || applied == '0;
  assign tmo_hit = tmo_cnt == TMO_W'(WRAP_TMO - 1);
  dds_shift_add_mul #(.AW(ADDR_W), .BW(TW_W)) u_mul (
    .Fg_CLK(Fg_CLK),
    .RESET(RESET),
    .start(take),
    .a(Address),
    .b(TW_W'(K_STEP)),
    .done(mul_done),
    .p(product)
  );
  always_ff @(posedge Fg_CLK or posedge RESET)
    if (RESET) state <= IDLE;
    else state <= state_nx;
  always_comb
    case (state)
      IDLE:      state_nx = take ? CALC : IDLE;
      CALC:      state_nx = mul_done ? WAIT_WRAP : CALC;
      WAIT_WRAP: state_nx = (wrap_ok || tmo_hit) ? LOAD : WAIT_WRAP;
      default:   state_nx = LoadAck ? IDLE : LOAD;
    endcase
  always_comb begin
    TuneLoad = state == LOAD;
    Busy = state != IDLE;
  end
  always_ff @(posedge Fg_CLK or posedge RESET)
    if (RESET) begin
      mode_q <= '0;
      pending <= 1'b0;
      tmo_cnt <= '0;
      TuneWord <= '0;
      WaveSel <= '0;
      WrapTmo <= 1'b0;
      applied <= '0;
    end else begin
      if (take) begin
        mode_q <= Mode;
        pending <= 1'b0;
      end else if (Busy && req) pending <= 1'b1;
      tmo_cnt <= state == WAIT_WRAP ? tmo_cnt + 1'b1 : '0;
      if (state == WAIT_WRAP && state_nx == LOAD) begin
        TuneWord <= product;
        WaveSel <= mode_q;
        WrapTmo <= !wrap_ok;
      end
      if (TuneLoad && LoadAck) applied <= TuneWord;
    end
endmodule

// File: tb/tb_dds_tune_ctrl.sv
// tb_dds_tune_ctrl: directed checks of load sequencing, wrap alignment, timeout, pending and reset
module tb_dds_tune_ctrl;
  logic Fg_CLK = 1'b0;
  logic RESET;
  logic [10:0] Address;
  logic FreqChng, PhaseWrap, LoadAck;
  logic [2:0] Mode;
  logic [31:0] TuneWord;
  logic [2:0] WaveSel;
  logic TuneLoad, Busy, WrapTmo;
  int n_chk = 0;
  int n_fail = 0;

  dds_tune_ctrl #(.WRAP_TMO(30)) dut (
    .Fg_CLK(Fg_CLK),
    .RESET(RESET),
    .Address(Address),
    .FreqChng(FreqChng),
    .Mode(Mode),
    .PhaseWrap(PhaseWrap),
    .LoadAck(LoadAck),
    .TuneWord(TuneWord),
    .WaveSel(WaveSel),
    .TuneLoad(TuneLoad),
    .Busy(Busy),
    .WrapTmo(WrapTmo)
  );

  always #5 Fg_CLK = ~Fg_CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Fg_CLK);
  endtask

  task automatic pulse_freq(input logic [10:0] a);
    Address = a;
    FreqChng = 1'b1;
    step(1);
    FreqChng = 1'b0;
  endtask

  task automatic ack;
    LoadAck = 1'b1;
    step(1);
    LoadAck = 1'b0;
  endtask

  initial begin
    RESET = 1'b1;
    Address = '0;
    FreqChng = 1'b0;
    PhaseWrap = 1'b0;
    LoadAck = 1'b0;
    Mode = 3'd0;
    step(1);
    check("rst_tuneload", TuneLoad, 0);
    check("rst_tuneword", TuneWord, 0);
    check("rst_wavesel", WaveSel, 0);
    check("rst_busy", Busy, 0);
    check("rst_wraptmo", WrapTmo, 0);
    RESET = 1'b0;
    // zero applied word: load 13 cycles after FreqChng with no wrap
    pulse_freq(11'd1);
    step(11);
    check("w0_busy_c12", Busy, 1);
    check("w0_noload_c12", TuneLoad, 0);
    step(1);
    check("w0_load_c13", TuneLoad, 1);
    check("w0_word", TuneWord, 179);
    step(2);
    check("w0_hold", TuneLoad, 1);
    ack();
    check("w0_drop", TuneLoad, 0);
    check("w0_idle", Busy, 0);
    // Address 1000, wrap 5 cycles after CALC, ack with TuneLoad
    pulse_freq(11'd1000);
    step(15);
    check("a1000_wait", TuneLoad, 0);
    PhaseWrap = 1'b1;
    step(1);
    PhaseWrap = 1'b0;
    check("a1000_load", TuneLoad, 1);
    check("a1000_word", TuneWord, 32'h0002_BB38);
    ack();
    check("a1000_single", TuneLoad, 0);
    check("a1000_idle", Busy, 0);
    check("a1000_tmo", WrapTmo, 0);
    // newer request during WAIT_WRAP becomes pending; latest address wins
    pulse_freq(11'd500);
    step(12);
    check("p_waitwrap", TuneLoad, 0);
    pulse_freq(11'd700);
    step(1);
    PhaseWrap = 1'b1;
    step(1);
    PhaseWrap = 1'b0;
    check("p_load1", TuneLoad, 1);
    check("p_word1", TuneWord, 89500);
    ack();
    check("p_idle_gap", Busy, 0);
    step(1);
    check("p_restart", Busy, 1);
    step(11);
    check("p_wait2", TuneLoad, 0);
    PhaseWrap = 1'b1;
    step(1);
    PhaseWrap = 1'b0;
    check("p_load2", TuneLoad, 1);
    check("p_word2", TuneWord, 125300);
    ack();
    step(3);
    check("p_no_repeat", Busy, 0);
    // wrap timeout forces the load and raises sticky WrapTmo
    pulse_freq(11'd10);
    step(40);
    check("t_before", TuneLoad, 0);
    step(1);
    check("t_load", TuneLoad, 1);
    check("t_flag", WrapTmo, 1);
    check("t_word", TuneWord, 1790);
    ack();
    check("t_sticky", WrapTmo, 1);
    pulse_freq(11'd20);
    step(11);
    PhaseWrap = 1'b1;
    step(1);
    PhaseWrap = 1'b0;
    check("t_clear_load", TuneLoad, 1);
    check("t_clear", WrapTmo, 0);
    check("t_word2", TuneWord, 3580);
    ack();
    // mode change alone retunes waveform; stray wrap in CALC ignored
    Mode = 3'd3;
    step(5);
    PhaseWrap = 1'b1;
    step(1);
    PhaseWrap = 1'b0;
    step(6);
    check("m_noload", TuneLoad, 0);
    check("m_old_sel", WaveSel, 0);
    PhaseWrap = 1'b1;
    step(1);
    PhaseWrap = 1'b0;
    check("m_load", TuneLoad, 1);
    check("m_sel", WaveSel, 3);
    check("m_word", TuneWord, 3580);
    ack();
    // reset during LOAD with a pending request abandons everything
    pulse_freq(11'd30);
    step(4);
    pulse_freq(11'd30);
    step(6);
    PhaseWrap = 1'b1;
    step(1);
    PhaseWrap = 1'b0;
    check("r_load", TuneLoad, 1);
    check("r_word", TuneWord, 5370);
    #2;
    RESET = 1'b1;
    Mode = 3'd0;
    #1;
    check("r_tuneload", TuneLoad, 0);
    check("r_tuneword", TuneWord, 0);
    check("r_wavesel", WaveSel, 0);
    check("r_busy", Busy, 0);
    check("r_wraptmo", WrapTmo, 0);
    step(1);
    RESET = 1'b0;
    step(3);
    check("r_no_pending", Busy, 0);
    pulse_freq(11'd5);
    step(11);
    check("r_w0_wait", TuneLoad, 0);
    step(1);
    check("r_w0_load", TuneLoad, 1);
    check("r_w0_word", TuneWord, 895);
    ack();
    check("r_w0_idle", Busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
